univ_shift_reg: RTL

//   Parametrised universal shift register: SISO/SIPO/PISO/PIPO in one block.

---
 rtl/univ_shift_reg.sv | 120 ++++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load, plus a frame counter.
// Optional ROTATE_EN macro adds the rot port (rotate instead of taking serial_in).
module univ_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     Rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     serial_in,
  input  logic [WIDTH-1:0]         par_in,
`ifdef ROTATE_EN
  input  logic                     rot,
`endif
  output logic [WIDTH-1:0]         par_out,
  output logic                     serial_out_r,
  output logic                     serial_out_l,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     frame_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;

  logic             right_in;
  logic             left_in;
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] shl_vec;
  logic             shift_op;

  // In rotate mode the bit falling off one end re-enters at the other.
`ifdef ROTATE_EN
  assign right_in = rot ? q_q[0]       : serial_in;
  assign left_in  = rot ? q_q[WIDTH-1] : serial_in;
`else
  assign right_in = serial_in;
  assign left_in  = serial_in;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bits
      if (gi == WIDTH - 1) begin : g_shr_top
        assign shr_vec[gi] = right_in;
      end else begin : g_shr_mid
        assign shr_vec[gi] = q_q[gi+1];
      end
      if (gi == 0) begin : g_shl_bot
        assign shl_vec[gi] = left_in;
      end else begin : g_shl_mid
        assign shl_vec[gi] = q_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    q_d          = q_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    shift_op     = 1'b0;
    if (en) begin
      case (mode_t'(mode))
        MODE_SHR: begin
          q_d      = shr_vec;
          shift_op = 1'b1;
        end
        MODE_SHL: begin
          q_d      = shl_vec;
          shift_op = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = par_in;
          cnt_d = '0;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
    // Any WIDTH shifts, regardless of direction, make one frame.
    if (shift_op) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      q_q          <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign par_out      = q_q;
  assign serial_out_r = q_q[0];
  assign serial_out_l = q_q[WIDTH-1];
  assign bit_cnt      = cnt_q;
  assign frame_done   = frame_done_q;

endmodule
